// File: rtl/leg_pkg.sv
// Shared types and defaults for the register-bank access path.
package leg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int unsigned REGBANK_ADDR_WIDTH = 10;

endpackage

// File: rtl/regbank_arbiter.sv
// Shares the register bank write port between execute-stage writes and a
// single-outstanding host/debug transaction, forcing the host through after MAX_WAIT.
module regbank_arbiter
    import leg_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = REGBANK_ADDR_WIDTH,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ex_write,
    input  logic [ADDR_WIDTH-1:0] i_ex_addr,
    input  logic [WORD_WIDTH-1:0] i_ex_wdata,
    output logic                  o_ex_stall,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [WORD_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_ack,
    output logic [WORD_WIDTH-1:0] o_host_rdata,
    output logic [ADDR_WIDTH-1:0] o_rb_addr,
    output logic [WORD_WIDTH-1:0] o_rb_wdata,
    output logic                  o_rb_write,
    input  logic [WORD_WIDTH-1:0] i_rb_rdata
);

    // A zero-width counter is illegal, so MAX_WAIT=0 still gets one bit.
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t            state_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic                  host_we_q;
    logic [ADDR_WIDTH-1:0] host_addr_q;
    logic [WORD_WIDTH-1:0] host_wdata_q;
    logic                  host_ack_q;
    logic [WORD_WIDTH-1:0] host_rdata_q;

    logic at_max_c;
    logic grant_c;

    assign at_max_c = (wait_cnt_q == WAIT_MAX);
    assign grant_c  = i_rst_n && (state_q == PEND) && (!i_ex_write || at_max_c);

    assign o_ex_stall   = i_rst_n && (state_q == PEND) && at_max_c && i_ex_write;
    assign o_host_ack   = host_ack_q;
    assign o_host_rdata = host_rdata_q;

    // Port mux: host only in the grant cycle; nothing is written while in reset.
    always_comb begin
        o_rb_addr  = i_ex_addr;
        o_rb_wdata = i_ex_wdata;
        o_rb_write = i_ex_write && i_rst_n;
        if (grant_c) begin
            o_rb_addr  = host_addr_q;
            o_rb_wdata = host_wdata_q;
            o_rb_write = host_we_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            host_we_q    <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_host_req) begin
                        host_we_q    <= i_host_we;
                        host_addr_q  <= i_host_addr;
                        host_wdata_q <= i_host_wdata;
                        wait_cnt_q   <= '0;
                        state_q      <= PEND;
                    end
                end
                PEND: begin
                    if (grant_c) begin
                        // Captured before any same-cycle write lands in the bank.
                        host_rdata_q <= i_rb_rdata;
                        host_ack_q   <= 1'b1;
                        state_q      <= ACK;
                    end else if (!at_max_c) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Shares the register bank's single address/write port between the execute stage and a host/debug access port. Execute-stage writes pass straight through in the same cycle; host read/write requests are queued one at a time and granted on a free cycle. If the execute stage holds the port for MAX_WAIT consecutive cycles, the arbiter stalls it for one cycle and grants the host. The block sits between `execute` and `regbank`.

## Interface

Parameters:
- WORD_WIDTH, 8, register word width.
- ADDR_WIDTH, 10, register bank address width.
- MAX_WAIT, 4, number of consecutive blocked pending cycles before the host is forced through; 0 means the host is forced immediately.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_ex_write  in  1  execute stage requests a register write this cycle.
- i_ex_addr  in  ADDR_WIDTH  execute write address.
- i_ex_wdata  in  WORD_WIDTH  execute write data.
- o_ex_stall  out  1  execute must hold its current instruction; its write is dropped this cycle.
- i_host_req  in  1  host request, level; sampled only in IDLE.
- i_host_we  in  1  1 = write, 0 = read.
- i_host_addr  in  ADDR_WIDTH  host address.
- i_host_wdata  in  WORD_WIDTH  host write data.
- o_host_ack  out  1  one-cycle pulse when the transaction completes.
- o_host_rdata  out  WORD_WIDTH  read data, valid while o_host_ack is high; held until the next ack.
- o_rb_addr  out  ADDR_WIDTH  to regbank i_addr.
- o_rb_wdata  out  WORD_WIDTH  to regbank i_value.
- o_rb_write  out  1  to regbank i_write.
- i_rb_rdata  in  WORD_WIDTH  regbank word at o_rb_addr, muxed at the integration level.

## Operation

- State machine: IDLE, PEND, ACK.
  - IDLE, with i_host_req=1: register we/addr/wdata, clear wait_cnt, go to PEND.
  - PEND, grant condition (i_ex_write=0, or wait_cnt==MAX_WAIT):
    - Drive the host address/data onto the port and set o_rb_write = host_we.
    - Register i_rb_rdata into o_host_rdata, then go to ACK.
  - PEND, otherwise: wait_cnt++ and the execute stage owns the port.
  - ACK: o_host_ack=1, then go to IDLE.
- Port mux:
  - The host owns the port only in the PEND grant cycle.
  - Otherwise o_rb_addr/o_rb_wdata/o_rb_write = i_ex_addr/i_ex_wdata/i_ex_write, combinationally.
- o_ex_stall = (state==PEND) && (wait_cnt==MAX_WAIT) && i_ex_write, combinational.
  - The stalled execute write is not performed.
  - The execute stage re-presents it next cycle. This prevents double-applied ADDs.
- Host read of an address written by the host in the same grant cycle is not possible: each transaction is a single op.
- A host read returns the bank contents before any write issued in that grant cycle.
- wait_cnt width is $clog2(MAX_WAIT+1); it saturates at MAX_WAIT and never wraps.
- The host must deassert i_host_req after the ack. A still-high req in IDLE starts a new transaction.

## Timing

- Reset values (i_rst_n=0 at a clock edge):
  - state=IDLE, wait_cnt=0, o_host_ack=0, o_host_rdata=0.
  - While i_rst_n=0: o_rb_write=0 and o_ex_stall=0, combinationally.
- Reset mid-transaction aborts it: no ack is issued and no host write occurs after the reset edge.
- Best-case host latency: req seen in IDLE at cycle 0, grant at cycle 1, ack at cycle 2.
- Worst case with continuous execute writes: grant at cycle 1+MAX_WAIT, ack at cycle 2+MAX_WAIT.
- o_ex_stall is high for at most one cycle per host transaction.
- Execute write throughput is therefore ≥ MAX_WAIT/(MAX_WAIT+3) under continuous host traffic.

## Structure

- Shared package `leg_pkg` holds:
  - the `arb_state_t` enum {IDLE, PEND, ACK};
  - the default REGBANK_ADDR_WIDTH (10).
- Single module; FSM, counter and mux are small enough that no sub-module is warranted.

## Test plan

All scenarios use WORD_WIDTH=8, MAX_WAIT=4.

1. Hold i_rst_n=0 for 2 cycles with i_host_req=1 and i_ex_write=1 -> o_rb_write=0, o_ex_stall=0, no ack. After release, ack 2 cycles later.
2. Host write addr 5 = 0x3C with execute idle -> o_rb_write=1, o_rb_addr=5, o_rb_wdata=0x3C at cycle 1; ack at cycle 2. A following host read of 5 returns 0x3C.
3. Execute writes addr 2 every cycle, with a host read of addr 9 (holding 0x55) pending:
   - PEND cycles 1-4 pass execute writes;
   - cycle 5: o_ex_stall=1, o_rb_write=0, o_rb_addr=9;
   - cycle 6: ack with rdata=0x55;
   - cycle 6: execute writes resume.
4. Host read of addr 7 pending while execute writes 7=0x11 (wait_cnt<4) -> execute write wins. In the next idle cycle the host is granted, and the ack carries 0x11.
5. i_rst_n=0 during PEND with host write 3=0xAA -> no ack, addr 3 is unchanged, state is IDLE.
6. MAX_WAIT=0 with execute writing continuously -> host request forces o_ex_stall=1 in the first PEND cycle, and ack follows the next cycle.
